// File: rtl/trena_rx_medida_pkg.sv
// ---------------------------------------------------------------------------
// trena_rx_medida_pkg
// Shared definitions for the trena measurement receiver.
//   - Default bit timing (50 MHz clock, 115200 baud). The trena transmitter
//     uses the same defaults.
//   - ASCII codes that the frame parser recognises.
//   - Receiver FSM state encoding. The numeric codes are also the value
//     shown on db_estado.
//   - eh_digito(): true when a 7-bit character is in the range '0'..'9'.
// ---------------------------------------------------------------------------
package trena_rx_medida_pkg;

  localparam int CICLOS_BIT_PADRAO = 434;
  localparam int MEIO_BIT_PADRAO   = 217;

  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_NOVE = 7'h39;
  localparam logic [6:0] ASCII_HASH = 7'h23;

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    ESPERA         = 4'd1,
    CONFIRMA_START = 4'd2,
    DADOS          = 4'd3,
    PARIDADE       = 4'd4,
    STOP           = 4'd5,
    ENTREGA        = 4'd6
  } estado_rx_t;

  function automatic logic eh_digito(input logic [6:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NOVE);
  endfunction

endpackage

// File: rtl/trena_rx_medida_rx_serial.sv
// ---------------------------------------------------------------------------
// rx_serial_7e1
// Character receiver for the 7E1 serial format: 1 start bit, 7 data bits
// sent LSB first, 1 even-parity bit and 1 stop bit.
// The line passes through a 2-flop synchroniser. A single counter times
// both the half-bit delay to the middle of the start bit and the full-bit
// intervals between later samples.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   entrada_serial  asynchronous serial line, idle high
//   dado[6:0]       last character received, valid while dado_pronto = 1
//   dado_pronto     high for one cycle (state ENTREGA) when a good
//                   character has arrived
//   erro_paridade   one-cycle pulse in the cycle after a stop sample with
//                   bad parity
//   erro_stop       one-cycle pulse in the cycle after a stop sample of 0
//   recebendo       high while a character is in progress (states 2..5)
//   estado[3:0]     current FSM state code
// ---------------------------------------------------------------------------
module rx_serial_7e1
  import trena_rx_medida_pkg::*;
#(
  parameter int CICLOS_BIT = CICLOS_BIT_PADRAO,
  parameter int MEIO_BIT   = MEIO_BIT_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dado,
  output logic       dado_pronto,
  output logic       erro_paridade,
  output logic       erro_stop,
  output logic       recebendo,
  output logic [3:0] estado
);

  localparam int CW = (CICLOS_BIT > 2) ? $clog2(CICLOS_BIT) : 1;
  localparam logic [CW-1:0] LIM_BIT  = CW'(CICLOS_BIT - 1);
  localparam logic [CW-1:0] LIM_MEIO = CW'(MEIO_BIT - 1);

  logic [1:0]    r_sync;
  estado_rx_t    r_estado;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_nbits;
  logic [6:0]    r_dado;
  logic          r_par;
  logic          r_dado_pronto;
  logic          r_erro_paridade;
  logic          r_erro_stop;
  logic          w_linha;

  assign w_linha = r_sync[1];

  // Both synchroniser flops reset to 0, so after reset the FSM does not
  // leave INICIAL until it has really seen the line high.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync          <= 2'b00;
      r_estado        <= INICIAL;
      r_cnt           <= '0;
      r_nbits         <= '0;
      r_dado          <= '0;
      r_par           <= 1'b0;
      r_dado_pronto   <= 1'b0;
      r_erro_paridade <= 1'b0;
      r_erro_stop     <= 1'b0;
    end else begin
      r_sync          <= {r_sync[0], entrada_serial};
      r_dado_pronto   <= 1'b0;
      r_erro_paridade <= 1'b0;
      r_erro_stop     <= 1'b0;
      case (r_estado)
        INICIAL: begin
          if (w_linha) r_estado <= ESPERA;
        end
        ESPERA: begin
          // In ESPERA the line has already been seen high, so a low level
          // means a falling edge.
          if (!w_linha) begin
            r_cnt    <= '0;
            r_estado <= CONFIRMA_START;
          end
        end
        CONFIRMA_START: begin
          if (r_cnt == LIM_MEIO) begin
            r_cnt   <= '0;
            r_nbits <= '0;
            // High at mid-start: the low pulse was a glitch.
            r_estado <= w_linha ? ESPERA : DADOS;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DADOS: begin
          if (r_cnt == LIM_BIT) begin
            r_cnt  <= '0;
            r_dado <= {w_linha, r_dado[6:1]};
            if (r_nbits == 3'd6) r_estado <= PARIDADE;
            else                 r_nbits  <= r_nbits + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        PARIDADE: begin
          if (r_cnt == LIM_BIT) begin
            r_cnt    <= '0;
            r_par    <= w_linha;
            r_estado <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == LIM_BIT) begin
            r_cnt <= '0;
            // A framing error takes priority. Returning to INICIAL makes
            // the receiver wait for the line to go high before it re-arms.
            if (!w_linha) begin
              r_erro_stop <= 1'b1;
              r_estado    <= INICIAL;
            end else if (^{r_dado, r_par}) begin
              r_erro_paridade <= 1'b1;
              r_estado        <= ESPERA;
            end else begin
              r_dado_pronto <= 1'b1;
              r_estado      <= ENTREGA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ENTREGA: begin
          r_estado <= ESPERA;
        end
        default: begin
          r_estado <= INICIAL;
        end
      endcase
    end
  end

  assign dado          = r_dado;
  assign dado_pronto   = r_dado_pronto;
  assign erro_paridade = r_erro_paridade;
  assign erro_stop     = r_erro_stop;
  assign estado        = r_estado;
  assign recebendo     = (r_estado == CONFIRMA_START) || (r_estado == DADOS) ||
                         (r_estado == PARIDADE)       || (r_estado == STOP);

endmodule

// File: rtl/trena_rx_medida.sv
// ---------------------------------------------------------------------------
// trena_rx_medida
// Receives the trena measurement frames "DDD#" from the serial line and
// presents the three digits as 12-bit BCD.
// Ports:
//   clock, reset    system clock, synchronous active-high reset
//   entrada_serial  asynchronous serial line, idle high
//   medida[11:0]    last valid measurement: [11:8] hundreds, [7:4] tens,
//                   [3:0] units
//   pronto          one-cycle pulse in the cycle medida is updated
//   erro            one-cycle pulse on any rejected character or frame
//   db_recebendo    high while a character is being received
//   db_estado[3:0]  receiver FSM state code
// ---------------------------------------------------------------------------
module trena_rx_medida
  import trena_rx_medida_pkg::*;
#(
  parameter int CICLOS_BIT = CICLOS_BIT_PADRAO,
  parameter int MEIO_BIT   = MEIO_BIT_PADRAO
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] medida,
  output logic        pronto,
  output logic        erro,
  output logic        db_recebendo,
  output logic [3:0]  db_estado
);

  logic [6:0]  w_dado;
  logic        w_dado_pronto;
  logic        w_erro_paridade;
  logic        w_erro_stop;
  logic        w_erro_rx;

  logic [1:0]  r_indice;
  logic [3:0]  r_centena;
  logic [3:0]  r_dezena;
  logic [3:0]  r_unidade;
  logic [11:0] r_medida;
  logic        r_pronto;
  logic        r_erro_quadro;

  rx_serial_7e1 #(
    .CICLOS_BIT (CICLOS_BIT),
    .MEIO_BIT   (MEIO_BIT)
  ) u_rx (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .dado           (w_dado),
    .dado_pronto    (w_dado_pronto),
    .erro_paridade  (w_erro_paridade),
    .erro_stop      (w_erro_stop),
    .recebendo      (db_recebendo),
    .estado         (db_estado)
  );

  assign w_erro_rx = w_erro_paridade | w_erro_stop;

  // Frame parser. r_indice is the position of the next expected character:
  // 0..2 are digits, 3 is the '#' terminator. A character error from the
  // receiver also abandons the partial frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_indice      <= 2'd0;
      r_centena     <= 4'h0;
      r_dezena      <= 4'h0;
      r_unidade     <= 4'h0;
      r_medida      <= 12'h000;
      r_pronto      <= 1'b0;
      r_erro_quadro <= 1'b0;
    end else begin
      r_pronto      <= 1'b0;
      r_erro_quadro <= 1'b0;
      if (w_erro_rx) begin
        r_indice <= 2'd0;
      end else if (w_dado_pronto) begin
        if (r_indice == 2'd3) begin
          if (w_dado == ASCII_HASH) begin
            r_medida <= {r_centena, r_dezena, r_unidade};
            r_pronto <= 1'b1;
          end else begin
            r_erro_quadro <= 1'b1;
          end
          r_indice <= 2'd0;
        end else if (eh_digito(w_dado)) begin
          case (r_indice)
            2'd0:    r_centena <= w_dado[3:0];
            2'd1:    r_dezena  <= w_dado[3:0];
            default: r_unidade <= w_dado[3:0];
          endcase
          r_indice <= r_indice + 2'd1;
        end else if ((w_dado == ASCII_HASH) && (r_indice == 2'd0)) begin
          // A stray '#' between frames resynchronises the parser and is
          // not an error.
          r_indice <= 2'd0;
        end else begin
          r_erro_quadro <= 1'b1;
          r_indice      <= 2'd0;
        end
      end
    end
  end

  // Receiver errors come one cycle after the stop sample and parser errors
  // one cycle after ENTREGA. They can never coincide, so erro stays a
  // single-cycle pulse.
  assign erro   = r_erro_quadro | w_erro_rx;
  assign pronto = r_pronto;
  assign medida = r_medida;

endmodule

// File: tb/tb_trena_rx_medida.sv
// ---------------------------------------------------------------------------
// tb_trena_rx_medida
// Directed self-checking bench for trena_rx_medida. It uses short bit
// timing so the whole run stays small.
// ---------------------------------------------------------------------------
module tb_trena_rx_medida;

  localparam int CB = 16;
  localparam int MB = 8;

  logic        clock;
  logic        reset;
  logic        entradaSerial;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic        dbRecebendo;
  logic [3:0]  dbEstado;

  int nCompared;
  int nFailed;
  int nPronto;
  int nErro;
  int nBoth;
  logic [11:0] medidaAtPronto;

  trena_rx_medida #(
    .CICLOS_BIT (CB),
    .MEIO_BIT   (MB)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entradaSerial),
    .medida         (medida),
    .pronto         (pronto),
    .erro           (erro),
    .db_recebendo   (dbRecebendo),
    .db_estado      (dbEstado)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count output pulses away from the active edge and remember the value
  // medida had while pronto was high.
  always @(negedge clock) begin
    if (!reset) begin
      if (pronto) begin
        nPronto        = nPronto + 1;
        medidaAtPronto = medida;
      end
      if (erro) nErro = nErro + 1;
      if (pronto && erro) nBoth = nBoth + 1;
    end
  end

  // Drives one 7E1 character. The line is left at the stop-bit level.
  task automatic sendChar(input logic [6:0] c, input bit flipPar, input bit stopVal);
    logic [9:0] bits;
    bits = {stopVal, (^c) ^ flipPar, c, 1'b0};
    for (int i = 0; i < 10; i++) begin
      entradaSerial = bits[i];
      repeat (CB) @(posedge clock);
    end
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) begin
      sendChar(s[i][6:0], 1'b0, 1'b1);
    end
    entradaSerial = 1'b1;
    repeat (2 * CB) @(posedge clock);
  endtask

  task automatic doReset();
    entradaSerial = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    reset = 1'b0;
    repeat (CB) @(posedge clock);
  endtask

  task automatic test_reset();
    entradaSerial = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    nCompared++;
    if (medida !== 12'h000) begin nFailed++; $display("[TB] FAIL reset_medida: got %h expected 000", medida); end
    nCompared++;
    if (pronto !== 1'b0) begin nFailed++; $display("[TB] FAIL reset_pronto: got %b expected 0", pronto); end
    nCompared++;
    if (erro !== 1'b0) begin nFailed++; $display("[TB] FAIL reset_erro: got %b expected 0", erro); end
    nCompared++;
    if (dbRecebendo !== 1'b0) begin nFailed++; $display("[TB] FAIL reset_recebendo: got %b expected 0", dbRecebendo); end
    nCompared++;
    if (dbEstado !== 4'd0) begin nFailed++; $display("[TB] FAIL reset_estado: got %0d expected 0", dbEstado); end
    reset = 1'b0;
    repeat (CB) @(posedge clock);
    @(negedge clock);
    nCompared++;
    if (dbEstado !== 4'd1) begin nFailed++; $display("[TB] FAIL idle_estado: got %0d expected 1", dbEstado); end
  endtask

  task automatic test_frame_valid();
    int p0, e0;
    doReset();
    p0 = nPronto; e0 = nErro;
    sendStr("247#");
    @(negedge clock);
    nCompared++;
    if (nPronto - p0 !== 1) begin nFailed++; $display("[TB] FAIL valid_pronto_count: got %0d expected 1", nPronto - p0); end
    nCompared++;
    if (nErro - e0 !== 0) begin nFailed++; $display("[TB] FAIL valid_erro_count: got %0d expected 0", nErro - e0); end
    nCompared++;
    if (medida !== 12'h247) begin nFailed++; $display("[TB] FAIL valid_medida: got %h expected 247", medida); end
    nCompared++;
    if (medidaAtPronto !== 12'h247) begin nFailed++; $display("[TB] FAIL valid_medida_at_pronto: got %h expected 247", medidaAtPronto); end
  endtask

  task automatic test_parity_error();
    int p0, e0;
    doReset();
    p0 = nPronto; e0 = nErro;
    sendChar(7'h31, 1'b0, 1'b1);
    sendChar(7'h32, 1'b1, 1'b1);
    entradaSerial = 1'b1;
    repeat (CB) @(posedge clock);
    @(negedge clock);
    nCompared++;
    if (nErro - e0 !== 1) begin nFailed++; $display("[TB] FAIL parity_erro_char: got %0d expected 1", nErro - e0); end
    sendStr("3#");
    @(negedge clock);
    nCompared++;
    if (nErro - e0 !== 2) begin nFailed++; $display("[TB] FAIL parity_erro_hash_idx1: got %0d expected 2", nErro - e0); end
    nCompared++;
    if (medida !== 12'h000) begin nFailed++; $display("[TB] FAIL parity_medida_kept: got %h expected 000", medida); end
    sendStr("123#");
    @(negedge clock);
    nCompared++;
    if (medida !== 12'h123) begin nFailed++; $display("[TB] FAIL parity_recover_medida: got %h expected 123", medida); end
    nCompared++;
    if (nPronto - p0 !== 1) begin nFailed++; $display("[TB] FAIL parity_pronto_count: got %0d expected 1", nPronto - p0); end
  endtask

  task automatic test_short_frame();
    int p0, e0;
    doReset();
    p0 = nPronto; e0 = nErro;
    sendStr("05#");
    @(negedge clock);
    nCompared++;
    if (nErro - e0 !== 1) begin nFailed++; $display("[TB] FAIL short_erro: got %0d expected 1", nErro - e0); end
    nCompared++;
    if (nPronto - p0 !== 0) begin nFailed++; $display("[TB] FAIL short_no_pronto: got %0d expected 0", nPronto - p0); end
    sendStr("009#");
    @(negedge clock);
    nCompared++;
    if (medida !== 12'h009) begin nFailed++; $display("[TB] FAIL short_next_medida: got %h expected 009", medida); end
    nCompared++;
    if (nErro - e0 !== 1) begin nFailed++; $display("[TB] FAIL short_next_erro: got %0d expected 1", nErro - e0); end
  endtask

  task automatic test_glitch();
    int e0;
    doReset();
    e0 = nErro;
    entradaSerial = 1'b0;
    repeat (MB / 2) @(posedge clock);
    entradaSerial = 1'b1;
    repeat (2 * CB) @(posedge clock);
    @(negedge clock);
    nCompared++;
    if (dbEstado !== 4'd1) begin nFailed++; $display("[TB] FAIL glitch_estado: got %0d expected 1", dbEstado); end
    nCompared++;
    if (nErro - e0 !== 0) begin nFailed++; $display("[TB] FAIL glitch_erro: got %0d expected 0", nErro - e0); end
    sendStr("999#");
    @(negedge clock);
    nCompared++;
    if (medida !== 12'h999) begin nFailed++; $display("[TB] FAIL glitch_medida: got %h expected 999", medida); end
  endtask

  task automatic test_stop_error();
    int e0;
    doReset();
    e0 = nErro;
    sendChar(7'h37, 1'b0, 1'b0);
    repeat (2 * CB) @(posedge clock);
    @(negedge clock);
    nCompared++;
    if (nErro - e0 !== 1) begin nFailed++; $display("[TB] FAIL stop_erro: got %0d expected 1", nErro - e0); end
    nCompared++;
    if (dbEstado !== 4'd0) begin nFailed++; $display("[TB] FAIL stop_estado_inicial: got %0d expected 0", dbEstado); end
    nCompared++;
    if (dbRecebendo !== 1'b0) begin nFailed++; $display("[TB] FAIL stop_recebendo: got %b expected 0", dbRecebendo); end
    entradaSerial = 1'b1;
    repeat (2 * CB) @(posedge clock);
    sendStr("310#");
    @(negedge clock);
    nCompared++;
    if (medida !== 12'h310) begin nFailed++; $display("[TB] FAIL stop_recover_medida: got %h expected 310", medida); end
  endtask

  task automatic test_reset_midframe();
    int p0, e0;
    logic [9:0] bits;
    doReset();
    sendStr("777#");
    sendChar(7'h34, 1'b0, 1'b1);
    // Second digit '5': start bit and three data bits, then reset.
    bits = {1'b1, ^7'h35, 7'h35, 1'b0};
    for (int i = 0; i < 4; i++) begin
      entradaSerial = bits[i];
      repeat (CB) @(posedge clock);
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    nCompared++;
    if (medida !== 12'h000) begin nFailed++; $display("[TB] FAIL midreset_medida: got %h expected 000", medida); end
    entradaSerial = 1'b1;
    reset = 1'b0;
    p0 = nPronto; e0 = nErro;
    repeat (2 * CB) @(posedge clock);
    sendStr("456#");
    @(negedge clock);
    nCompared++;
    if (medida !== 12'h456) begin nFailed++; $display("[TB] FAIL midreset_medida_after: got %h expected 456", medida); end
    nCompared++;
    if (nPronto - p0 !== 1) begin nFailed++; $display("[TB] FAIL midreset_pronto_count: got %0d expected 1", nPronto - p0); end
    nCompared++;
    if (nErro - e0 !== 0) begin nFailed++; $display("[TB] FAIL midreset_erro_count: got %0d expected 0", nErro - e0); end
  endtask

  initial begin
    nCompared = 0; nFailed = 0;
    nPronto = 0; nErro = 0; nBoth = 0;
    medidaAtPronto = 12'h000;
    reset = 1'b1;
    entradaSerial = 1'b1;

    test_reset();
    test_frame_valid();
    test_parity_error();
    test_short_frame();
    test_glitch();
    test_stop_error();
    test_reset_midframe();

    nCompared++;
    if (nBoth !== 0) begin nFailed++; $display("[TB] FAIL pronto_erro_exclusive: got %0d overlaps expected 0", nBoth); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
